// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and line levels.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_IDLE      = 1'b1;
   localparam logic UART_START     = 1'b0;
endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte and status pulses out.
interface uart_rx_if;
   import uart_pkg::*;
   logic                      rx;
   logic [UART_DATA_BITS-1:0] dout;
   logic                      valid;
   logic                      frame_err;
   logic                      busy;

   modport slave  (input rx,  output dout, output valid, output frame_err, output busy);
   modport master (output rx, input dout,  input valid,  input frame_err,  input busy);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, reset to RST_VAL.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] ff_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ff_q <= {2{RST_VAL}};
      else        ff_q <= {ff_q[0], d_i};
   end

   assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling via a bit timer, start-glitch rejection,
// stop-bit check with one-cycle valid / frame_err pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_rx_if.slave  bus
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(UART_DATA_BITS);
   localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

   uart_state_t               state_q, state_d;
   logic [TW-1:0]             tmr_q, tmr_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [UART_DATA_BITS-1:0] sh_q, sh_d, dout_q, dout_d;
   logic                      valid_q, valid_d, ferr_q, ferr_d;
   logic                      rx_s, rx_prev_q;

   uart_sync2 #(.RST_VAL(UART_IDLE)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus.rx),
      .q_o   (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tmr_q     <= '0;
         idx_q     <= '0;
         sh_q      <= '0;
         dout_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         rx_prev_q <= UART_IDLE;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         idx_q     <= idx_d;
         sh_q      <= sh_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         rx_prev_q <= rx_s;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + 1'b1;
      idx_d   = idx_q;
      sh_d    = sh_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         // Edge-triggered arm: a line stuck low never starts a frame.
         IDLE: begin
            tmr_d = '0;
            if (rx_prev_q == UART_IDLE && rx_s == UART_START) state_d = START;
         end
         START: if (tmr_q == HALF_END) begin
            tmr_d   = '0;
            idx_d   = '0;
            state_d = (rx_s == UART_START) ? DATA : IDLE;
         end
         DATA: if (tmr_q == BIT_END) begin
            tmr_d = '0;
            sh_d  = {rx_s, sh_q[UART_DATA_BITS-1:1]};
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_d = STOP;
         end
         STOP: if (tmr_q == BIT_END) begin
            tmr_d   = '0;
            state_d = IDLE;
            if (rx_s == UART_IDLE) begin
               dout_d  = sh_q;
               valid_d = 1'b1;
            end else begin
               ferr_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.dout      = dout_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = ferr_q;
   assign bus.busy      = (state_q != IDLE);
endmodule
